// File: rtl/meep_uart_pkg.sv
// Shared definitions for the AXI4-Lite UART: register map, response codes,
// CTRL/STAT bit positions and the state encodings of the serial engines.
package meep_uart_pkg;

   localparam logic [1:0] UART_DATA = 2'd0;
   localparam logic [1:0] UART_STAT = 2'd1;
   localparam logic [1:0] UART_CTRL = 2'd2;
   localparam logic [1:0] UART_DIV  = 2'd3;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int CTRL_RXIE  = 0;
   localparam int CTRL_TXIE  = 1;
   localparam int CTRL_RXCLR = 2;
   localparam int CTRL_TXCLR = 3;
   localparam int CTRL_LOOP  = 4;

   localparam int STAT_RX_VALID = 0;
   localparam int STAT_RX_FULL  = 1;
   localparam int STAT_TX_EMPTY = 2;
   localparam int STAT_TX_FULL  = 3;
   localparam int STAT_OVERRUN  = 4;
   localparam int STAT_TX_BUSY  = 5;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic {WIDLE, WRESP} wr_state_t;
   typedef enum logic {RIDLE, RRESP} rd_state_t;

endpackage

// File: rtl/meep_uart_fifo.sv
// Synchronous first-word-fall-through FIFO with one extra pointer bit so that
// full and empty are distinguished without a separate counter.
module meep_uart_fifo
   import meep_uart_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   input  logic             clr,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign dout    = mem[rd_ptr[AW-1:0]];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push && !clr) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/meep_axil_uart.sv
// AXI4-Lite 8N1 UART with TX/RX FIFOs and a level interrupt.
// Optional internal loopback (CTRL[4]) is built when MEEP_UART_LOOPBACK_EN is defined.
module meep_axil_uart
   import meep_uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_RESET  = 868,
   parameter int DIV_W      = 16
) (
   input  logic        chipset_clk,
   input  logic        chipset_rst,
   input  logic [12:0] uart_axi_awaddr,
   input  logic        uart_axi_awvalid,
   output logic        uart_axi_awready,
   input  logic [31:0] uart_axi_wdata,
   input  logic [3:0]  uart_axi_wstrb,
   input  logic        uart_axi_wvalid,
   output logic        uart_axi_wready,
   output logic [1:0]  uart_axi_bresp,
   output logic        uart_axi_bvalid,
   input  logic        uart_axi_bready,
   input  logic [12:0] uart_axi_araddr,
   input  logic        uart_axi_arvalid,
   output logic        uart_axi_arready,
   output logic [31:0] uart_axi_rdata,
   output logic [1:0]  uart_axi_rresp,
   output logic        uart_axi_rvalid,
   input  logic        uart_axi_rready,
   input  logic        uart_rx,
   output logic        uart_tx,
   output logic        uart_irq
);

   function automatic logic [DIV_W-1:0] nz_div(input logic [DIV_W-1:0] d);
      return (d == '0) ? DIV_W'(1) : d;
   endfunction

   logic             clk;
   logic             rst;
   assign clk = chipset_clk;
   assign rst = chipset_rst;

   wr_state_t        wstate;
   rd_state_t        rstate;
   logic             bvalid_q;
   logic [1:0]       bresp_q;
   logic             arready_q;
   logic             rvalid_q;
   logic [31:0]      rdata_q;
   logic [31:0]      rd_mux;
   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] eff_div;
   logic [DIV_W:0]   half_w;
   logic [DIV_W-1:0] rx_half;
   logic             rxie_q;
   logic             txie_q;
   logic             loop_en;
   logic             ovr_q;
   logic             irq_q;
   logic [5:0]       stat;

   logic             wr_hs;
   logic             wr_en;
   logic [1:0]       wr_reg;
   logic             ctrl_wr;
   logic             ar_hs;
   logic [1:0]       rd_reg;

   logic             tx_push, tx_pop, tx_clr, tx_full, tx_empty;
   logic [7:0]       tx_dout;
   logic             rx_pop, rx_clr, rx_full, rx_empty;
   logic [7:0]       rx_dout;

   tx_state_t        tx_state;
   logic [DIV_W-1:0] tx_cnt;
   logic [2:0]       tx_bit;
   logic [7:0]       tx_sh;
   logic             tx_line;
   logic             tx_busy;

   rx_state_t        rx_state;
   logic [DIV_W-1:0] rx_cnt;
   logic [2:0]       rx_bit;
   logic [7:0]       rx_sh;
   logic             rx_sync_p0;
   logic             rx_sync_p1;
   logic             rx_in;
   logic             rx_prev;
   logic             rx_push_q;

   logic             unused_bits;
   assign unused_bits = ^{uart_axi_awaddr[12:4], uart_axi_awaddr[1:0], uart_axi_araddr[12:4],
                          uart_axi_araddr[1:0], uart_axi_wdata, uart_axi_wstrb[3:1]};

   assign eff_div = nz_div(div_q);
   assign half_w  = ({1'b0, eff_div} + (DIV_W+1)'(1)) >> 1;
   assign rx_half = half_w[DIV_W-1:0];

   // AW and W are only ever taken together.
   assign wr_hs   = (wstate == WIDLE) && uart_axi_awvalid && uart_axi_wvalid;
   assign wr_en   = wr_hs && uart_axi_wstrb[0];
   assign wr_reg  = uart_axi_awaddr[3:2];
   assign ctrl_wr = wr_en && (wr_reg == UART_CTRL);
   assign tx_push = wr_en && (wr_reg == UART_DATA) && !tx_full;
   assign tx_clr  = ctrl_wr && uart_axi_wdata[CTRL_TXCLR];
   assign rx_clr  = ctrl_wr && uart_axi_wdata[CTRL_RXCLR];

   assign ar_hs   = (rstate == RIDLE) && arready_q && uart_axi_arvalid;
   assign rd_reg  = uart_axi_araddr[3:2];
   assign rx_pop  = ar_hs && (rd_reg == UART_DATA) && !rx_empty;

   assign tx_busy = (tx_state != TX_IDLE);
   assign tx_pop  = (tx_state == TX_IDLE) && !tx_empty;
   assign stat    = {tx_busy, ovr_q, tx_full, tx_empty, rx_full, !rx_empty};

   assign uart_axi_awready = wr_hs;
   assign uart_axi_wready  = wr_hs;
   assign uart_axi_bvalid  = bvalid_q;
   assign uart_axi_bresp   = bresp_q;
   assign uart_axi_arready = arready_q;
   assign uart_axi_rvalid  = rvalid_q;
   assign uart_axi_rdata   = rdata_q;
   assign uart_axi_rresp   = RESP_OKAY;
   assign uart_irq         = irq_q;

`ifdef MEEP_UART_LOOPBACK_EN
   logic loop_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          loop_q <= 1'b0;
      else if (ctrl_wr) loop_q <= uart_axi_wdata[CTRL_LOOP];
   end
   assign loop_en = loop_q;
   assign uart_tx = loop_q ? 1'b1 : tx_line;
   assign rx_in   = loop_q ? tx_line : rx_sync_p1;
`else
   assign loop_en = 1'b0;
   assign uart_tx = tx_line;
   assign rx_in   = rx_sync_p1;
`endif

   meep_uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .rst(rst), .push(tx_push), .din(uart_axi_wdata[7:0]), .pop(tx_pop),
      .clr(tx_clr), .dout(tx_dout), .full(tx_full), .empty(tx_empty)
   );

   meep_uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .rst(rst), .push(rx_push_q), .din(rx_sh), .pop(rx_pop),
      .clr(rx_clr), .dout(rx_dout), .full(rx_full), .empty(rx_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wstate   <= WIDLE;
         bvalid_q <= 1'b0;
         bresp_q  <= RESP_OKAY;
         rxie_q   <= 1'b0;
         txie_q   <= 1'b0;
         div_q    <= DIV_W'(DIV_RESET);
      end else begin
         case (wstate)
            WIDLE: begin
               if (wr_hs) begin
                  wstate   <= WRESP;
                  bvalid_q <= 1'b1;
                  bresp_q  <= (wr_en && (wr_reg == UART_DATA) && tx_full) ? RESP_SLVERR : RESP_OKAY;
                  if (ctrl_wr) begin
                     rxie_q <= uart_axi_wdata[CTRL_RXIE];
                     txie_q <= uart_axi_wdata[CTRL_TXIE];
                  end
                  if (wr_en && (wr_reg == UART_DIV)) div_q <= uart_axi_wdata[DIV_W-1:0];
               end
            end
            WRESP: begin
               if (uart_axi_bready) begin
                  wstate   <= WIDLE;
                  bvalid_q <= 1'b0;
               end
            end
         endcase
      end
   end

   always_comb begin
      rd_mux = '0;
      case (rd_reg)
         UART_DATA: if (!rx_empty) rd_mux = 32'(rx_dout);
         UART_STAT: rd_mux = 32'(stat);
         UART_CTRL: rd_mux = 32'({loop_en, 2'b00, txie_q, rxie_q});
         UART_DIV:  rd_mux = 32'(div_q);
      endcase
   end

   // arready comes up the cycle after reset and again after every completed response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rstate    <= RIDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
      end else begin
         case (rstate)
            RIDLE: begin
               if (ar_hs) begin
                  rstate    <= RRESP;
                  arready_q <= 1'b0;
                  rvalid_q  <= 1'b1;
                  rdata_q   <= rd_mux;
               end else begin
                  arready_q <= 1'b1;
               end
            end
            RRESP: begin
               if (uart_axi_rready) begin
                  rstate    <= RIDLE;
                  rvalid_q  <= 1'b0;
                  arready_q <= 1'b1;
               end
            end
         endcase
      end
   end

   // A new overrun in the same cycle as a STAT read stays visible.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovr_q <= 1'b0;
         irq_q <= 1'b0;
      end else begin
         if (ar_hs && (rd_reg == UART_STAT)) ovr_q <= 1'b0;
         if (rx_push_q && rx_full)           ovr_q <= 1'b1;
         irq_q <= (rxie_q && !rx_empty) || (txie_q && tx_empty && !tx_busy);
      end
   end

   // Serialiser: the divisor is re-read at every bit boundary.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_sh    <= '0;
         tx_line  <= 1'b1;
      end else begin
         case (tx_state)
            TX_IDLE: begin
               tx_line <= 1'b1;
               if (!tx_empty) begin
                  tx_sh    <= tx_dout;
                  tx_line  <= 1'b0;
                  tx_cnt   <= eff_div;
                  tx_state <= TX_START;
               end
            end
            TX_START: begin
               if (tx_cnt == '0) begin
                  tx_line  <= tx_sh[0];
                  tx_cnt   <= eff_div;
                  tx_bit   <= '0;
                  tx_state <= TX_DATA;
               end else begin
                  tx_cnt <= tx_cnt - DIV_W'(1);
               end
            end
            TX_DATA: begin
               if (tx_cnt == '0) begin
                  tx_cnt <= eff_div;
                  if (tx_bit == 3'd7) begin
                     tx_line  <= 1'b1;
                     tx_state <= TX_STOP;
                  end else begin
                     tx_line <= tx_sh[1];
                     tx_sh   <= tx_sh >> 1;
                     tx_bit  <= tx_bit + 3'd1;
                  end
               end else begin
                  tx_cnt <= tx_cnt - DIV_W'(1);
               end
            end
            TX_STOP: begin
               if (tx_cnt == '0) tx_state <= TX_IDLE;
               else              tx_cnt   <= tx_cnt - DIV_W'(1);
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_sync_p0 <= 1'b1;
         rx_sync_p1 <= 1'b1;
      end else begin
         rx_sync_p0 <= uart_rx;
         rx_sync_p1 <= rx_sync_p0;
      end
   end

   // Deserialiser: half a bit after the falling edge, then one full bit per sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state  <= RX_IDLE;
         rx_cnt    <= '0;
         rx_bit    <= '0;
         rx_sh     <= '0;
         rx_prev   <= 1'b1;
         rx_push_q <= 1'b0;
      end else begin
         rx_prev   <= rx_in;
         rx_push_q <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               if (!rx_in && rx_prev) begin
                  rx_cnt   <= rx_half;
                  rx_state <= RX_START;
               end
            end
            RX_START: begin
               if (rx_cnt == '0) begin
                  if (!rx_in) begin
                     rx_cnt   <= eff_div;
                     rx_bit   <= '0;
                     rx_state <= RX_DATA;
                  end else begin
                     rx_state <= RX_IDLE;
                  end
               end else begin
                  rx_cnt <= rx_cnt - DIV_W'(1);
               end
            end
            RX_DATA: begin
               if (rx_cnt == '0) begin
                  rx_sh  <= {rx_in, rx_sh[7:1]};
                  rx_cnt <= eff_div;
                  if (rx_bit == 3'd7) rx_state <= RX_STOP;
                  else                rx_bit   <= rx_bit + 3'd1;
               end else begin
                  rx_cnt <= rx_cnt - DIV_W'(1);
               end
            end
            RX_STOP: begin
               if (rx_cnt == '0) begin
                  rx_push_q <= rx_in;
                  rx_state  <= RX_IDLE;
               end else begin
                  rx_cnt <= rx_cnt - DIV_W'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_meep_axil_uart.sv
// Directed bench for meep_axil_uart: register vector table plus hand-written
// TX framing, TX fill, RX overrun, interrupt, loopback and async-reset sequences.
module tb_meep_axil_uart;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [12:0] awaddr = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b0;
   logic [12:0] araddr = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready = 1'b0;
   logic        uart_rx = 1'b1;
   logic        uart_tx;
   logic        uart_irq;

   int n_cmp = 0;
   int n_err = 0;

`ifdef MEEP_UART_LOOPBACK_EN
   localparam logic [31:0] LOOP_EXP = 32'h10;
`else
   localparam logic [31:0] LOOP_EXP = 32'h00;
`endif

   meep_axil_uart dut (
      .chipset_clk(clk), .chipset_rst(rst),
      .uart_axi_awaddr(awaddr), .uart_axi_awvalid(awvalid), .uart_axi_awready(awready),
      .uart_axi_wdata(wdata), .uart_axi_wstrb(wstrb), .uart_axi_wvalid(wvalid),
      .uart_axi_wready(wready), .uart_axi_bresp(bresp), .uart_axi_bvalid(bvalid),
      .uart_axi_bready(bready), .uart_axi_araddr(araddr), .uart_axi_arvalid(arvalid),
      .uart_axi_arready(arready), .uart_axi_rdata(rdata), .uart_axi_rresp(rresp),
      .uart_axi_rvalid(rvalid), .uart_axi_rready(rready),
      .uart_rx(uart_rx), .uart_tx(uart_tx), .uart_irq(uart_irq)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1);
   end

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endfunction

   task automatic axi_write(input logic [12:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
      int t;
      @(negedge clk);
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      #1;
      t = 0;
      while (!awready && t < 20) begin
         @(negedge clk); #1; t++;
      end
      if (!awready) begin
         check("aw_handshake_timeout", 32'(awready), 32'd1);
         awvalid = 1'b0; wvalid = 1'b0; resp = 2'b11;
         return;
      end
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      check("bvalid_latency", 32'(bvalid), 32'd1);
      resp = bresp;
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
   endtask

   task automatic axi_read(input logic [12:0] a, output logic [31:0] d, output logic [1:0] resp);
      int t;
      @(negedge clk);
      araddr = a; arvalid = 1'b1;
      #1;
      t = 0;
      while (!arready && t < 20) begin
         @(negedge clk); #1; t++;
      end
      if (!arready) begin
         check("ar_handshake_timeout", 32'(arready), 32'd1);
         arvalid = 1'b0; d = '1; resp = 2'b11;
         return;
      end
      @(negedge clk);
      arvalid = 1'b0;
      check("rvalid_latency", 32'(rvalid), 32'd1);
      d = rdata; resp = rresp;
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
   endtask

   task automatic send_rx(input logic [7:0] b);
      logic [9:0] f;
      f = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         uart_rx = f[i];
         repeat (7) @(negedge clk);
      end
      repeat (6) @(negedge clk);
   endtask

   typedef struct {
      bit          wr;
      logic [12:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp;
      logic [1:0]  resp;
   } vec_t;

   vec_t vt [16];

   initial begin
      logic [31:0] d;
      logic [1:0]  r;
      logic [9:0]  frame;
      int          t;
      int          bad;

      vt[0]  = '{1'b0, 13'h00C, 32'h0,    4'hF, 32'd868,  2'b00};
      vt[1]  = '{1'b0, 13'h004, 32'h0,    4'hF, 32'h04,   2'b00};
      vt[2]  = '{1'b0, 13'h008, 32'h0,    4'hF, 32'h00,   2'b00};
      vt[3]  = '{1'b0, 13'h000, 32'h0,    4'hF, 32'h00,   2'b00};
      vt[4]  = '{1'b1, 13'h008, 32'h03,   4'hF, 32'h0,    2'b00};
      vt[5]  = '{1'b0, 13'h008, 32'h0,    4'hF, 32'h03,   2'b00};
      vt[6]  = '{1'b1, 13'h008, 32'h00,   4'hE, 32'h0,    2'b00};
      vt[7]  = '{1'b0, 13'h008, 32'h0,    4'hF, 32'h03,   2'b00};
      vt[8]  = '{1'b1, 13'h008, 32'h1C,   4'hF, 32'h0,    2'b00};
      vt[9]  = '{1'b0, 13'h008, 32'h0,    4'hF, LOOP_EXP, 2'b00};
      vt[10] = '{1'b1, 13'h00C, 32'h1234, 4'hF, 32'h0,    2'b00};
      vt[11] = '{1'b0, 13'h1FC, 32'h0,    4'hF, 32'h1234, 2'b00};
      vt[12] = '{1'b1, 13'h008, 32'h00,   4'hF, 32'h0,    2'b00};
      vt[13] = '{1'b1, 13'h7EC, 32'h03,   4'hF, 32'h0,    2'b00};
      vt[14] = '{1'b0, 13'h00C, 32'h0,    4'hF, 32'h03,   2'b00};
      vt[15] = '{1'b0, 13'h014, 32'h0,    4'hF, 32'h04,   2'b00};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_awready", 32'(awready), 0);
      check("rst_wready", 32'(wready), 0);
      check("rst_arready", 32'(arready), 0);
      check("rst_bvalid", 32'(bvalid), 0);
      check("rst_rvalid", 32'(rvalid), 0);
      check("rst_bresp", 32'(bresp), 0);
      check("rst_rresp", 32'(rresp), 0);
      check("rst_rdata", rdata, 0);
      check("rst_uart_tx", 32'(uart_tx), 1);
      check("rst_uart_irq", 32'(uart_irq), 0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_uart_tx", 32'(uart_tx), 1);

      // Register vectors
      for (int i = 0; i < 16; i++) begin
         if (vt[i].wr) begin
            axi_write(vt[i].addr, vt[i].data, vt[i].strb, r);
            check($sformatf("vec%0d_bresp", i), 32'(r), 32'(vt[i].resp));
         end else begin
            axi_read(vt[i].addr, d, r);
            check($sformatf("vec%0d_rdata", i), d, vt[i].exp);
            check($sformatf("vec%0d_rresp", i), 32'(r), 32'(vt[i].resp));
         end
      end

      // TX framing of 0xA5 at DIV=3: 10 bits of 4 cycles each
      frame = {1'b1, 8'hA5, 1'b0};
      fork
         axi_write(13'h000, 32'hA5, 4'hF, r);
         begin
            t = 0;
            while (uart_tx !== 1'b0 && t < 60) begin
               @(negedge clk); t++;
            end
            if (uart_tx !== 1'b0) begin
               check("tx_start_timeout", 32'(uart_tx), 0);
            end else begin
               for (int i = 0; i < 40; i++) begin
                  check($sformatf("tx_a5_bit%0d_cyc%0d", i / 4, i % 4), 32'(uart_tx), 32'(frame[i / 4]));
                  @(negedge clk);
               end
               check("tx_idle_after_stop", 32'(uart_tx), 1);
            end
         end
      join
      check("tx_a5_bresp", 32'(r), 0);
      repeat (4) @(negedge clk);

      // TX fill with a long first byte in flight
      axi_write(13'h00C, 32'd1000, 4'hF, r);
      for (int k = 0; k < 18; k++) begin
         axi_write(13'h000, 32'(k + 1), 4'hF, r);
         check($sformatf("fill_wr%0d_bresp", k + 1), 32'(r), (k < 17) ? 32'h0 : 32'h2);
      end
      axi_read(13'h004, d, r);
      check("fill_stat_full", d, 32'h28);
      axi_write(13'h008, 32'h08, 4'hF, r);
      axi_read(13'h004, d, r);
      check("txclr_stat", d, 32'h24);
      axi_write(13'h00C, 32'd3, 4'hF, r);
      t = 0;
      d = 32'hFFFF;
      while (d !== 32'h04 && t < 500) begin
         axi_read(13'h004, d, r);
         t++;
      end
      check("tx_drain_idle_stat", d, 32'h04);

      // RX: 0x3C then 16 more frames, no reads in between
      axi_write(13'h00C, 32'd7, 4'hF, r);
      send_rx(8'h3C);
      for (int k = 1; k < 16; k++) send_rx(8'(k));
      axi_read(13'h004, d, r);
      check("rx_full_stat", d, 32'h07);
      send_rx(8'h99);
      axi_read(13'h004, d, r);
      check("rx_overrun_stat", d, 32'h17);
      axi_read(13'h004, d, r);
      check("rx_overrun_cleared", d, 32'h07);
      axi_read(13'h000, d, r);
      check("rx_first_byte", d, 32'h3C);
      check("rx_first_rresp", 32'(r), 0);
      axi_read(13'h000, d, r);
      check("rx_second_byte", d, 32'h01);
      axi_read(13'h004, d, r);
      check("rx_after_pop_stat", d, 32'h05);
      axi_write(13'h008, 32'h04, 4'hF, r);
      axi_read(13'h004, d, r);
      check("rxclr_stat", d, 32'h04);

      // Interrupt on RX ready
      axi_write(13'h008, 32'h01, 4'hF, r);
      repeat (2) @(negedge clk);
      check("irq_idle", 32'(uart_irq), 0);
      send_rx(8'h77);
      check("irq_after_push", 32'(uart_irq), 1);
      @(negedge clk);
      araddr = 13'h000; arvalid = 1'b1;
      #1;
      t = 0;
      while (!arready && t < 20) begin
         @(negedge clk); #1; t++;
      end
      check("irq_rd_arready", 32'(arready), 1);
      @(negedge clk);
      arvalid = 1'b0;
      check("irq_lag_high", 32'(uart_irq), 1);
      @(negedge clk);
      check("irq_fall", 32'(uart_irq), 0);
      check("irq_rvalid_held", 32'(rvalid), 1);
      check("irq_rd_data", rdata, 32'h77);
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      axi_read(13'h000, d, r);
      check("empty_rd_data", d, 0);
      check("empty_rd_rresp", 32'(r), 0);
      axi_write(13'h008, 32'h00, 4'hF, r);

`ifdef MEEP_UART_LOOPBACK_EN
      // Internal loopback
      axi_write(13'h00C, 32'd3, 4'hF, r);
      axi_write(13'h008, 32'h10, 4'hF, r);
      bad = 0;
      fork
         axi_write(13'h000, 32'h5A, 4'hF, r);
         for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) bad++;
         end
      join
      check("loop_tx_held_high", 32'(bad), 0);
      t = 0;
      d = 32'h0;
      while (d[0] !== 1'b1 && t < 50) begin
         axi_read(13'h004, d, r);
         t++;
      end
      check("loop_rx_valid", 32'(d[0]), 1);
      axi_read(13'h000, d, r);
      check("loop_rx_byte", d, 32'h5A);
      axi_write(13'h008, 32'h00, 4'hF, r);
`else
      bad = 0;
`endif

      // Asynchronous reset in the middle of a frame
      axi_write(13'h00C, 32'd3, 4'hF, r);
      axi_write(13'h000, 32'h00, 4'hF, r);
      t = 0;
      while (uart_tx !== 1'b0 && t < 60) begin
         @(negedge clk); t++;
      end
      repeat (8) @(negedge clk);
      check("midframe_tx_low", 32'(uart_tx), 0);
      #2 rst = 1'b1;
      #1;
      check("async_rst_tx_high", 32'(uart_tx), 1);
      check("async_rst_bvalid", 32'(bvalid), 0);
      @(negedge clk);
      rst = 1'b0;
      axi_read(13'h00C, d, r);
      check("post_rst_div", d, 32'd868);
      axi_read(13'h004, d, r);
      check("post_rst_stat", d, 32'h04);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
